fsm_report_decoder: RTL and testbench
=====================================

Name: fsm_report_decoder

Overview:
- Receive-side decoder for the serial y1 marker stream produced by the team's fsm_report sequencer.
- Samples y1 every clock and recognises a complete report frame: a marker run of one or more 1s, then exactly GAP 0s, then a single closing 1.
- Flags each good, aborted and malformed frame, and keeps wrap-around counters for each, for use by the status logic and the bench scoreboard.

Parameters:
- GAP, 5: number of 0 samples required between marker and closing 1; legal range 1..2^GAP_W-1.
- GAP_W, 3: width of the gap counter.
- CNT_W, 8: width of the frame_cnt, abort_cnt and err_cnt counters.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- y1  input  1  serial marker stream, synchronous to clk.
- frame_ok  output  1  one-cycle pulse: valid frame completed.
- frame_abort  output  1  one-cycle pulse: 1 arrived before GAP zeros.
- frame_err  output  1  one-cycle pulse: gap exceeded GAP zeros.
- frame_cnt  output  CNT_W  count of good frames.
- abort_cnt  output  CNT_W  count of aborts.
- err_cnt  output  CNT_W  count of errors.
- state  output  2  current decoder state, for debug.

Behaviour:
- Reset: while rst_n is low, every output is 0 and all internal state is cleared. Reset takes effect asynchronously; release is seen on the next clk edge.
- States: IDLE=0, MARK=1, GAP=2 (encoding 3 is unused and recovers to IDLE).
- Gap counter: zc, width GAP_W. It is cleared whenever the decoder enters MARK.
- IDLE:
  - y1=1: go to MARK.
  - y1=0: stay in IDLE.
- MARK:
  - y1=1: stay in MARK. Marker runs of any length are legal.
  - y1=0: zc=1, go to GAP.
- GAP with zc<GAP:
  - y1=0: zc=zc+1.
  - y1=1: pulse frame_abort, increment abort_cnt, go to MARK. The 1 is treated as the start of a new marker.
- GAP with zc==GAP:
  - y1=1: pulse frame_ok, increment frame_cnt, go to IDLE. The closing 1 is consumed and is not a marker.
  - y1=0: pulse frame_err, increment err_cnt, go to IDLE.
- Latency and timing:
  - All outputs are registered.
  - Each pulse is high for exactly the one cycle following the clk edge that sampled the deciding y1.
  - Counters update on that same edge.
- Exclusivity: at most one of frame_ok, frame_abort, frame_err is high in any cycle.
- Back-to-back frames: a closing 1 followed by another 1 gives frame_ok for the first; the second 1 then moves IDLE to MARK and starts a new frame. No frame is lost.
- Counter width: counters wrap modulo 2^CNT_W (255+1 reads 0 at the default width) and never saturate.
- Reset mid-frame: any partial frame is discarded and no pulse is emitted for it.
- y1 is sampled raw and has no synchronizer, because the upstream source is on the same clock.

Decomposition:
- Shared package fsm_report_pkg holds:
  - the decoder state encoding: IDLE, MARK, GAP;
  - default constants REPORT_GAP=5 and REPORT_GAP_W=3, shared with the fsm_report sequencer so both ends agree on the gap length.
- The block stays flat with no sub-module: one state register, one gap counter and three event counters.

Test Plan:
- Reset with rst_n=0 held for 3 cycles, y1 toggling -> all outputs 0 and state=0 throughout.
- Basic frame: y1=0,0,1,0,0,0,0,0,1,0 -> frame_ok high for one cycle after the final 1 is sampled; frame_cnt=1; abort_cnt=0; err_cnt=0; state returns to 0.
- Long marker: y1=1,1,1,0,0,0,0,0,1 -> one frame_ok; frame_cnt=1; state reads 1 for three cycles, then 2 for five cycles.
- Abort then recovery: y1=1,0,0,1,0,0,0,0,0,1 -> frame_abort on the 4th sample, then frame_ok; abort_cnt=1; frame_cnt=1.
- Overlong gap and back-to-back frames:
  - y1=1 followed by six 0s -> frame_err on the 6th 0; err_cnt=1; state=0.
  - Then 1,0×5,1,1,0×5,1 -> two frame_ok pulses; frame_cnt=2.
  - Then drive 255 further frames -> frame_cnt wraps to 1.
- Reset mid-GAP: rst_n pulsed low after 1,0,0 -> no pulse; counters 0. The following good frame then yields frame_cnt=1.

Source files
------------

// File: rtl/fsm_report_pkg.sv
// rtl/fsm_report_pkg.sv - shared encodings and gap defaults for the fsm_report sequencer and decoder
package fsm_report_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MARK = 2'd1,
    S_GAP  = 2'd2
  } dec_state_e;

  localparam int REPORT_GAP   = 5;
  localparam int REPORT_GAP_W = 3;

endpackage

// File: rtl/fsm_report_decoder.sv
// rtl/fsm_report_decoder.sv - frame decoder for the y1 marker stream (marker run, GAP zeros, closing 1)
// Flags good / aborted / malformed frames with one-cycle pulses and keeps wrapping event counters.
module fsm_report_decoder
  import fsm_report_pkg::*;
#(
  parameter int GAP   = REPORT_GAP,
  parameter int GAP_W = REPORT_GAP_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y1,
  output logic             frame_ok,
  output logic             frame_abort,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] abort_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] ZC_ONE   = GAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dec_state_e       state_q, state_d;
  logic [GAP_W-1:0] zc_q, zc_d;
  logic             ok_q, ok_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] frame_cnt_q, abort_cnt_q, err_cnt_q;

  always_comb begin
    state_d = state_q;
    zc_d    = zc_q;
    ok_d    = 1'b0;
    abort_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (y1) begin
          state_d = S_MARK;
          zc_d    = '0;
        end
      end
      S_MARK: begin
        if (y1) begin
          zc_d = '0;
        end else begin
          state_d = S_GAP;
          zc_d    = ZC_ONE;
        end
      end
      S_GAP: begin
        if (zc_q < GAP_LAST) begin
          // An early 1 both aborts this frame and opens the next marker run.
          if (y1) begin
            abort_d = 1'b1;
            state_d = S_MARK;
            zc_d    = '0;
          end else begin
            zc_d = zc_q + ZC_ONE;
          end
        end else begin
          ok_d    = y1;
          err_d   = ~y1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        zc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      zc_q        <= '0;
      ok_q        <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      zc_q    <= zc_d;
      ok_q    <= ok_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      if (ok_d)    frame_cnt_q <= frame_cnt_q + CNT_ONE;
      if (abort_d) abort_cnt_q <= abort_cnt_q + CNT_ONE;
      if (err_d)   err_cnt_q   <= err_cnt_q + CNT_ONE;
    end
  end

  assign frame_ok    = ok_q;
  assign frame_abort = abort_q;
  assign frame_err   = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign abort_cnt   = abort_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fsm_report_decoder.sv
// tb/tb_fsm_report_decoder.sv - vector-table bench for fsm_report_decoder with an expected-value queue
module tb_fsm_report_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       y1;
    logic       frame_ok, frame_abort, frame_err;
    logic [7:0] frame_cnt, abort_cnt, err_cnt;
    logic [1:0] state;
    logic       done = 1'b0;

    always #5 clk = ~clk;

    fsm_report_decoder #(.GAP(5), .GAP_W(3), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y1         (y1),
        .frame_ok   (frame_ok),
        .frame_abort(frame_abort),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt),
        .abort_cnt  (abort_cnt),
        .err_cnt    (err_cnt),
        .state      (state)
    );

    typedef struct packed {
        logic [7:0] sec;
        logic       rst_n;
        logic       y1;
        logic       ok;
        logic       ab;
        logic       er;
        logic [1:0] st;
        logic [7:0] fc;
        logic [7:0] ac;
        logic [7:0] ec;
    } vec_t;

    vec_t       tbl[$];
    vec_t       exp_q[$];
    logic [7:0] sec;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic row(input logic r, input logic yv, input logic ok, input logic ab, input logic er,
                       input logic [1:0] st, input logic [7:0] fc, input logic [7:0] ac, input logic [7:0] ec);
        vec_t t;
        t.sec = sec; t.rst_n = r; t.y1 = yv; t.ok = ok; t.ab = ab; t.er = er;
        t.st = st; t.fc = fc; t.ac = ac; t.ec = ec;
        tbl.push_back(t);
    endtask

    task automatic rst_rows(input int n);
        for (int i = 0; i < n; i++) row(1'b0, i[0], 0, 0, 0, 2'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic good_frame(input logic [7:0] fc, input logic [7:0] ac, input logic [7:0] ec);
        logic [7:0] prev;
        prev = fc - 8'd1;
        row(1, 1, 0, 0, 0, 2'd1, prev, ac, ec);
        for (int i = 0; i < 5; i++) row(1, 0, 0, 0, 0, 2'd2, prev, ac, ec);
        row(1, 1, 1, 0, 0, 2'd0, fc, ac, ec);
    endtask

    task automatic build();
        sec = 8'd1; rst_rows(3);
        sec = 8'd2;
        row(1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        row(1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        row(1, 1, 0, 0, 0, 2'd1, 0, 0, 0);
        for (int i = 0; i < 5; i++) row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(1, 1, 1, 0, 0, 2'd0, 1, 0, 0);
        row(1, 0, 0, 0, 0, 2'd0, 1, 0, 0);
        rst_rows(2);
        sec = 8'd3;
        for (int i = 0; i < 3; i++) row(1, 1, 0, 0, 0, 2'd1, 0, 0, 0);
        for (int i = 0; i < 5; i++) row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(1, 1, 1, 0, 0, 2'd0, 1, 0, 0);
        rst_rows(2);
        sec = 8'd4;
        row(1, 1, 0, 0, 0, 2'd1, 0, 0, 0);
        row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(1, 1, 0, 1, 0, 2'd1, 0, 1, 0);
        for (int i = 0; i < 5; i++) row(1, 0, 0, 0, 0, 2'd2, 0, 1, 0);
        row(1, 1, 1, 0, 0, 2'd0, 1, 1, 0);
        row(1, 0, 0, 0, 0, 2'd0, 1, 1, 0);
        rst_rows(2);
        sec = 8'd5;
        row(1, 1, 0, 0, 0, 2'd1, 0, 0, 0);
        for (int i = 0; i < 5; i++) row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(1, 0, 0, 0, 1, 2'd0, 0, 0, 1);
        sec = 8'd6;
        good_frame(8'd1, 8'd0, 8'd1);
        good_frame(8'd2, 8'd0, 8'd1);
        sec = 8'd7;
        for (int k = 1; k <= 255; k++) good_frame(8'(2 + k), 8'd0, 8'd1);
        row(1, 0, 0, 0, 0, 2'd0, 8'd1, 0, 1);
        sec = 8'd8;
        rst_rows(2);
        row(1, 1, 0, 0, 0, 2'd1, 0, 0, 0);
        row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        row(0, 1, 0, 0, 0, 2'd0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        good_frame(8'd1, 8'd0, 8'd0);
        row(1, 0, 0, 0, 0, 2'd0, 1, 0, 0);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        if (!done) begin
            $display("FAIL: timeout waiting for vector table to complete");
            $finish;
        end
    end

    initial begin
        vec_t e;
        rst_n = 1'b0;
        y1    = 1'b0;
        build();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n;
            y1    = tbl[i].y1;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({frame_ok, frame_abort, frame_err, state, frame_cnt, abort_cnt, err_cnt} !==
                {e.ok, e.ab, e.er, e.st, e.fc, e.ac, e.ec}) begin
                n_bad++;
                $display("FAIL sec%0d vec%0d: got ok=%b ab=%b er=%b st=%0d fc=%0d ac=%0d ec=%0d, want ok=%b ab=%b er=%b st=%0d fc=%0d ac=%0d ec=%0d",
                         e.sec, i, frame_ok, frame_abort, frame_err, state, frame_cnt, abort_cnt, err_cnt,
                         e.ok, e.ab, e.er, e.st, e.fc, e.ac, e.ec);
            end
            if (!rst_n && ({frame_ok, frame_abort, frame_err, state, frame_cnt, abort_cnt, err_cnt} !== '0)) begin
                n_bad++;
                $display("FAIL sec%0d vec%0d: outputs not cleared while rst_n low", e.sec, i);
            end
            if ((32'(frame_ok) + 32'(frame_abort) + 32'(frame_err)) > 1) begin
                n_bad++;
                $display("FAIL sec%0d vec%0d: more than one frame pulse high", e.sec, i);
            end
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else            $display("PASS");
        $finish;
    end

endmodule
